// File: rtl/fwd_pkg.sv
// Shared constants for the operand-forwarding control path: mux select codes,
// divide-hold state encoding and the default register index width.
package fwd_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  localparam logic [0:0] DIV_IDLE = 1'b0;
  localparam logic [0:0] DIV_BUSY = 1'b1;

endpackage

// File: rtl/fwd_compare.sv
// Priority compare for one source register against the shadow EX and MEM
// destinations; the younger EX producer wins over MEM.
module fwd_compare
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  ex_v_i,
  input  logic                  ex_wr_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  mem_v_i,
  input  logic                  mem_wr_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  output fwd_sel_t              sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (rs_i != '0) begin
      if (ex_v_i && ex_wr_i && (ex_rd_i == rs_i)) begin
        sel_o = FWD_EXMEM;
      end else if (mem_v_i && mem_wr_i && (mem_rd_i == rs_i)) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select, load-use stall and multi-cycle divide hold for the
// 5-stage core. Optional stall counters are built when HAZARD_PERF_EN is defined.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int DIV_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ID_VALID,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic [REG_ADDR_W-1:0] ID_RD,
  input  logic                  ID_REGWRITE,
  input  logic                  ID_MEMREAD,
  input  logic                  ID_DIV,
  input  logic                  FLUSH,
  output logic [1:0]            FWD_SEL_A,
  output logic [1:0]            FWD_SEL_B,
  output logic                  STALL,
  output logic                  EX_HOLD
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           PERF_LU_STALLS,
  output logic [31:0]           PERF_DIV_STALLS
`endif
);

  localparam logic [3:0] DIV_LOAD = (DIV_CYCLES > 1) ? 4'(DIV_CYCLES - 2) : 4'd0;

  logic                  ex_v_q, ex_wr_q, ex_ld_q, ex_div_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  mem_v_q, mem_wr_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  fwd_sel_t              sel_a_q, sel_b_q, sel_a_c, sel_b_c;
  logic                  hold, lu_hit, lu_stall, ex_load, div_start;

  fwd_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_a (
    .rs_i(ID_RS1), .ex_v_i(ex_v_q), .ex_wr_i(ex_wr_q), .ex_rd_i(ex_rd_q),
    .mem_v_i(mem_v_q), .mem_wr_i(mem_wr_q), .mem_rd_i(mem_rd_q), .sel_o(sel_a_c)
  );

  fwd_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_b (
    .rs_i(ID_RS2), .ex_v_i(ex_v_q), .ex_wr_i(ex_wr_q), .ex_rd_i(ex_rd_q),
    .mem_v_i(mem_v_q), .mem_wr_i(mem_wr_q), .mem_rd_i(mem_rd_q), .sel_o(sel_b_c)
  );

  // The divide stays parked in EX for the whole busy window.
  assign hold      = (state_q == DIV_BUSY) && ex_div_q;
  assign lu_hit    = ID_VALID && ex_v_q && ex_ld_q && (ex_rd_q != '0) &&
                     ((ex_rd_q == ID_RS1) || (ex_rd_q == ID_RS2));
  assign lu_stall  = !hold && !FLUSH && lu_hit;
  assign ex_load   = ID_VALID && !FLUSH && !lu_hit;
  assign div_start = ex_load && ID_DIV && (DIV_CYCLES > 1);

  assign STALL     = hold || lu_stall;
  assign EX_HOLD   = hold;
  assign FWD_SEL_A = sel_a_q;
  assign FWD_SEL_B = sel_b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hold) begin
      if (cnt_q == 4'd0) begin
        state_d = DIV_IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (div_start) begin
      state_d = DIV_BUSY;
      cnt_d   = DIV_LOAD;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ex_v_q   <= 1'b0;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      ex_div_q <= 1'b0;
      ex_rd_q  <= '0;
      mem_v_q  <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_rd_q <= '0;
      sel_a_q  <= FWD_RF;
      sel_b_q  <= FWD_RF;
      state_q  <= DIV_IDLE;
      cnt_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hold) begin
        mem_v_q <= 1'b0;
      end else begin
        mem_v_q  <= ex_v_q;
        mem_wr_q <= ex_wr_q;
        mem_rd_q <= ex_rd_q;
        ex_v_q   <= ex_load;
        ex_wr_q  <= ID_REGWRITE;
        ex_ld_q  <= ID_MEMREAD;
        ex_div_q <= ID_DIV;
        ex_rd_q  <= ID_RD;
        // A bubble entering EX must not steer the muxes.
        sel_a_q  <= ex_load ? sel_a_c : FWD_RF;
        sel_b_q  <= ex_load ? sel_b_c : FWD_RF;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_div_q;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      perf_lu_q  <= 32'd0;
      perf_div_q <= 32'd0;
    end else begin
      if (lu_stall) perf_lu_q <= perf_lu_q + 32'd1;
      if (hold)     perf_div_q <= perf_div_q + 32'd1;
    end
  end

  assign PERF_LU_STALLS  = perf_lu_q;
  assign PERF_DIV_STALLS = perf_div_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding, load-use, divide hold,
// flush priority and mid-divide reset.
module tb_fwd_hazard_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ID_VALID;
  logic [4:0] ID_RS1, ID_RS2, ID_RD;
  logic       ID_REGWRITE, ID_MEMREAD, ID_DIV, FLUSH;
  logic [1:0] FWD_SEL_A, FWD_SEL_B;
  logic       STALL, EX_HOLD;
`ifdef HAZARD_PERF_EN
  logic [31:0] PERF_LU_STALLS, PERF_DIV_STALLS;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  fwd_hazard_unit #(.REG_ADDR_W(5), .DIV_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
    .ID_REGWRITE(ID_REGWRITE), .ID_MEMREAD(ID_MEMREAD), .ID_DIV(ID_DIV),
    .FLUSH(FLUSH), .FWD_SEL_A(FWD_SEL_A), .FWD_SEL_B(FWD_SEL_B),
    .STALL(STALL), .EX_HOLD(EX_HOLD)
`ifdef HAZARD_PERF_EN
    , .PERF_LU_STALLS(PERF_LU_STALLS), .PERF_DIV_STALLS(PERF_DIV_STALLS)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wr, input logic ld,
                        input logic dv, input logic fl);
    ID_VALID = v; ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd;
    ID_REGWRITE = wr; ID_MEMREAD = ld; ID_DIV = dv; FLUSH = fl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("rst_sel_a", 32'(FWD_SEL_A), 32'h0);
    check("rst_sel_b", 32'(FWD_SEL_B), 32'h0);
    RESET = 1'b1; #1;
    check("rst_stall", 32'(STALL), 32'h0);
    check("rst_hold", 32'(EX_HOLD), 32'h0);

    // add x5,x1,x2 ; sub x6,x5,x3
    set_id(1, 1, 2, 5, 1, 0, 0, 0); tick();
    set_id(1, 5, 3, 6, 1, 0, 0, 0); #1;
    check("t1_stall", 32'(STALL), 32'h0);
    tick();
    check("t1_sel_a", 32'(FWD_SEL_A), 32'h1);
    check("t1_sel_b", 32'(FWD_SEL_B), 32'h0);

    // add x5 ; nop ; or x7,x0,x5
    set_id(1, 1, 2, 5, 1, 0, 0, 0); tick();
    set_id(1, 0, 0, 0, 1, 0, 0, 0); tick();
    set_id(1, 0, 5, 7, 1, 0, 0, 0); tick();
    check("t2_sel_a", 32'(FWD_SEL_A), 32'h0);
    check("t2_sel_b", 32'(FWD_SEL_B), 32'h2);

    // lw x8,0(x1) ; add x9,x8,x8
    set_id(1, 1, 0, 8, 1, 1, 0, 0); tick();
    set_id(1, 8, 8, 9, 1, 0, 0, 0); #1;
    check("t3_stall", 32'(STALL), 32'h1);
    check("t3_hold", 32'(EX_HOLD), 32'h0);
    tick();
    check("t3_bubble_a", 32'(FWD_SEL_A), 32'h0);
    check("t3_bubble_b", 32'(FWD_SEL_B), 32'h0);
    check("t3_stall_one", 32'(STALL), 32'h0);
    tick();
    check("t3_sel_a", 32'(FWD_SEL_A), 32'h2);
    check("t3_sel_b", 32'(FWD_SEL_B), 32'h2);

    // div x10,x1,x2 ; add x11,x10,x0 (FLUSH pulsed mid-divide is ignored)
    set_id(1, 1, 2, 10, 1, 0, 1, 0); #1;
    check("t4_pre_stall", 32'(STALL), 32'h0);
    tick();
    set_id(1, 10, 0, 11, 1, 0, 0, 0); #1;
    check("t4_c1_stall", 32'(STALL), 32'h1);
    check("t4_c1_hold", 32'(EX_HOLD), 32'h1);
    check("t4_c1_sel_a", 32'(FWD_SEL_A), 32'h0);
    tick();
    set_id(1, 10, 0, 11, 1, 0, 0, 1); #1;
    check("t4_c2_stall", 32'(STALL), 32'h1);
    check("t4_c2_hold", 32'(EX_HOLD), 32'h1);
    tick();
    set_id(1, 10, 0, 11, 1, 0, 0, 0); #1;
    check("t4_c3_stall", 32'(STALL), 32'h1);
    check("t4_c3_hold", 32'(EX_HOLD), 32'h1);
    tick(); #1;
    check("t4_end_stall", 32'(STALL), 32'h0);
    check("t4_end_hold", 32'(EX_HOLD), 32'h0);
    tick();
    check("t4_sel_a", 32'(FWD_SEL_A), 32'h1);
    check("t4_sel_b", 32'(FWD_SEL_B), 32'h0);

    // lw x12 ; add x13,x12,x0 with FLUSH ; sub x15,x13,x12
    set_id(1, 1, 0, 12, 1, 1, 0, 0); tick();
    set_id(1, 12, 0, 13, 1, 0, 0, 1); #1;
    check("t5_flush_stall", 32'(STALL), 32'h0);
    tick();
    set_id(1, 13, 12, 15, 1, 0, 0, 0); #1;
    check("t5_next_stall", 32'(STALL), 32'h0);
    tick();
    check("t5_sel_a", 32'(FWD_SEL_A), 32'h0);
    check("t5_sel_b", 32'(FWD_SEL_B), 32'h2);

    // div x10,x15,x1 then reset during the second busy cycle
    set_id(1, 15, 1, 10, 1, 0, 1, 0); #1;
    check("t6_pre_stall", 32'(STALL), 32'h0);
    tick();
    set_id(1, 10, 0, 11, 1, 0, 0, 0); #1;
    check("t6_c1_stall", 32'(STALL), 32'h1);
    check("t6_c1_sel_a", 32'(FWD_SEL_A), 32'h1);
    tick();
`ifdef HAZARD_PERF_EN
    check("t6_perf_lu", PERF_LU_STALLS, 32'd1);
    check("t6_perf_div", PERF_DIV_STALLS, 32'd4);
`endif
    RESET = 1'b0; #1;
    check("t6_c2_hold", 32'(EX_HOLD), 32'h1);
    tick();
    RESET = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t6_rst_stall", 32'(STALL), 32'h0);
    check("t6_rst_hold", 32'(EX_HOLD), 32'h0);
    check("t6_rst_sel_a", 32'(FWD_SEL_A), 32'h0);
    check("t6_rst_sel_b", 32'(FWD_SEL_B), 32'h0);
`ifdef HAZARD_PERF_EN
    check("t6_rst_perf_lu", PERF_LU_STALLS, 32'd0);
    check("t6_rst_perf_div", PERF_DIV_STALLS, 32'd0);
`endif
    tick(); #1;
    check("t6_after_stall", 32'(STALL), 32'h0);
    check("t6_after_hold", 32'(EX_HOLD), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
